aes_req_arbiter: RTL and testbench
==================================

Name: aes_req_arbiter

Overview:
Sequencing controller that shares one combinational AES encryptor/decryptor pair between two requesters (A, B). It arbitrates round-robin, registers the selected plaintext/ciphertext and key onto the core input bus, and holds them stable for a fixed multicycle settle window. It then captures the enc or dec result and returns it through a valid/ready response channel tagged with requester ID and mode. It sits between the system-side command sources and the aes_encryptor/aes_decryptor instances.

Parameters:
WAIT_CYCLES, 4, cycles core inputs are held stable before result capture (multicycle path budget); legal range 1..15
BLOCK_W, 128, AES block and key width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
a_valid  in  1  requester A command valid
a_ready  out  1  requester A command accepted this cycle
a_mode  in  1  0 = encrypt, 1 = decrypt
a_text  in  BLOCK_W  A input block
a_key  in  BLOCK_W  A key
b_valid, b_ready, b_mode, b_text, b_key  same as A, for requester B
core_text  out  BLOCK_W  registered block to both cores
core_key  out  BLOCK_W  registered key to both cores
core_enc_result  in  BLOCK_W  encryptor output
core_dec_result  in  BLOCK_W  decryptor output
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  1  0 = A, 1 = B
rsp_mode  out  1  mode of completed op
rsp_data  out  BLOCK_W  captured result
busy  out  1  high in any state other than IDLE

Behaviour:
- Single clock clk; rst synchronous, active-high, sampled on rising edge.
- Reset: state IDLE; core_text, core_key, rsp_data = 0; rsp_valid, rsp_id, rsp_mode, busy = 0; RR pointer favours A; wait counter = 0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - a_ready = grant_a, b_ready = grant_b; both combinational, at most one high.
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the requester the pointer favours.
  - On accept edge: core_text/core_key/mode/id latch from the granted requester; pointer moves to the other requester; counter = WAIT_CYCLES-1; state -> WAIT.
- a_ready, b_ready = 0 in WAIT and RESP.
- Requester rule: once valid is asserted, it holds with stable payload until ready. The arbiter does not check this.
- WAIT:
  - core_* held constant.
  - Counter decrements each cycle.
  - On the edge where counter == 0: rsp_data = core_enc_result if mode = 0, else core_dec_result; rsp_valid = 1; state -> RESP.
- Latency: accept on edge k -> rsp_valid high after edge k+WAIT_CYCLES.
- RESP:
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready edge: rsp_valid = 0; state -> IDLE.
  - The next accept is possible in the following cycle, so minimum issue interval is WAIT_CYCLES+2 cycles.
- rsp_data and core_* are not cleared after a handshake; only rsp_valid drops.
- Pointer only moves on an accept. A lone requester is served repeatedly.
- rst asserted in WAIT or RESP: aborts the op, discards the result, and returns all outputs to reset values next cycle. No response is emitted for the aborted op.
- Counter width: 4 bits. WAIT_CYCLES = 1 gives capture on the first WAIT edge.

Decomposition:
- Shared package aes_pkg:
  - AES_BLOCK_W = 128
  - mode encoding constants MODE_ENC = 0, MODE_DEC = 1
  - requester ID constants REQ_A = 0, REQ_B = 1
  - state enum {IDLE, WAIT, RESP}
- One natural sub-module, rr_arb2: two-requester round-robin arbiter.
  - Inputs: req[1:0], advance.
  - Outputs: grant[1:0] (one-hot or zero), pointer register.
- FSM, counter and capture logic live in aes_req_arbiter. The cores are instantiated at the level above.

Test Plan:
- FIPS-197 vector: A enc, text 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, rsp_ready = 1 -> rsp_valid WAIT_CYCLES after accept; rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a; rsp_id 0; rsp_mode 0.
- B dec of 69c4e0d86a7b0430d8cdb78070b4c55a, same key -> rsp_data 00112233445566778899aabbccddeeff; rsp_id 1; rsp_mode 1.
- A and B valid continuously from reset -> grants alternate A, B, A, B; never both ready in one cycle; rsp_id sequence 0, 1, 0, 1.
- Backpressure: rsp_ready low for 10 cycles in RESP -> rsp_valid/rsp_data stable, a_ready = 0 throughout; release -> one handshake, IDLE next cycle.
- Mid-op reset: rst pulsed 2 cycles after accept -> no rsp_valid for that op, all outputs 0, pointer favours A; a fresh A request then completes normally.
- WAIT_CYCLES = 1 build: rsp_valid high one edge after accept; back-to-back A requests issue every 3 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and types for the AES request arbiter and its helpers.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. ptr_q names the requester that wins a tie;
// it flips to the other requester whenever a grant is taken.
module rr_arb2
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       ptr_q
);

  logic ptr_d;

  always_comb begin
    if (req == 2'b11) begin
      grant = (ptr_q == REQ_B) ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && (grant != 2'b00)) begin
      ptr_d = grant[0] ? REQ_B : REQ_A;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= REQ_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one combinational AES enc/dec core pair between requesters A and B:
// latches the winner onto the core bus, waits a multicycle settle window, returns the result.
//
// state | meaning
// IDLE  | no op in flight; requesters may be granted
// WAIT  | core inputs held stable while the combinational cores settle
// RESP  | captured result presented on rsp_*, waiting for rsp_ready
module aes_req_arbiter
  import aes_pkg::*;
#(
  parameter int WAIT_CYCLES = 4,
  parameter int BLOCK_W     = AES_BLOCK_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic               a_mode,
  input  logic [BLOCK_W-1:0] a_text,
  input  logic [BLOCK_W-1:0] a_key,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic               b_mode,
  input  logic [BLOCK_W-1:0] b_text,
  input  logic [BLOCK_W-1:0] b_key,
  output logic [BLOCK_W-1:0] core_text,
  output logic [BLOCK_W-1:0] core_key,
  input  logic [BLOCK_W-1:0] core_enc_result,
  input  logic [BLOCK_W-1:0] core_dec_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic               rsp_mode,
  output logic [BLOCK_W-1:0] rsp_data,
  output logic               busy
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  arb_state_e         state_q;
  logic [BLOCK_W-1:0] core_text_q, core_key_q, rsp_data_q;
  logic               mode_q, id_q;
  logic               rsp_valid_q, rsp_id_q, rsp_mode_q, busy_q;
  logic [3:0]         cnt_q;

  logic [1:0]         req, grant;
  logic               accept;
  logic               rr_ptr_unused;
  logic [BLOCK_W-1:0] text_d, key_d, result_d;
  logic               mode_d;

  assign req    = (state_q == IDLE) ? {b_valid, a_valid} : 2'b00;
  assign accept = grant != 2'b00;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (accept),
    .grant   (grant),
    .ptr_q   (rr_ptr_unused)
  );

  always_comb begin
    text_d   = grant[1] ? b_text : a_text;
    key_d    = grant[1] ? b_key  : a_key;
    mode_d   = grant[1] ? b_mode : a_mode;
    result_d = (mode_q == MODE_DEC) ? core_dec_result : core_enc_result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      core_text_q <= '0;
      core_key_q  <= '0;
      rsp_data_q  <= '0;
      mode_q      <= MODE_ENC;
      id_q        <= REQ_A;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= REQ_A;
      rsp_mode_q  <= MODE_ENC;
      busy_q      <= 1'b0;
      cnt_q       <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            core_text_q <= text_d;
            core_key_q  <= key_d;
            mode_q      <= mode_d;
            id_q        <= grant[1] ? REQ_B : REQ_A;
            cnt_q       <= CNT_INIT;
            busy_q      <= 1'b1;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            rsp_data_q  <= result_d;
            rsp_id_q    <= id_q;
            rsp_mode_q  <= mode_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          // rsp_data and core_* stay as they are; only the valid drops
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a_ready   = grant[0];
  assign b_ready   = grant[1];
  assign core_text = core_text_q;
  assign core_key  = core_key_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_mode  = rsp_mode_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Self-checking bench for aes_req_arbiter; stand-in cores return the FIPS-197
// vector results for the known block/key and an arbitrary bijection otherwise.
module tb_aes_req_arbiter;

  localparam int W  = 4;
  localparam int BW = 128;

  localparam logic [BW-1:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [BW-1:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [BW-1:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          a_valid, a_mode, b_valid, b_mode, rsp_ready;
  logic [BW-1:0] a_text, a_key, b_text, b_key;

  logic          a_ready, b_ready, rsp_valid, rsp_id, rsp_mode, busy;
  logic [BW-1:0] core_text, core_key, core_enc_result, core_dec_result, rsp_data;

  logic          w1_a_ready, w1_b_ready, w1_rsp_valid, w1_rsp_id, w1_rsp_mode, w1_busy;
  logic [BW-1:0] w1_core_text, w1_core_key, w1_enc, w1_dec, w1_rsp_data;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [BW-1:0] enc_f(input logic [BW-1:0] t, input logic [BW-1:0] k);
    if (t == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return t ^ {k[63:0], k[127:64]} ^ 128'h5a5a_1234_c3c3_9876_0f0f_abcd_f00d_7777;
  endfunction

  function automatic logic [BW-1:0] dec_f(input logic [BW-1:0] t, input logic [BW-1:0] k);
    if (t == FIPS_CT && k == FIPS_KEY) return FIPS_PT;
    return {t[126:0], t[127]} ^ k;
  endfunction

  function automatic logic [BW-1:0] expect_f(input logic m, input logic [BW-1:0] t,
                                             input logic [BW-1:0] k);
    return m ? dec_f(t, k) : enc_f(t, k);
  endfunction

  function automatic logic [BW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  assign core_enc_result = enc_f(core_text, core_key);
  assign core_dec_result = dec_f(core_text, core_key);
  assign w1_enc          = enc_f(w1_core_text, w1_core_key);
  assign w1_dec          = dec_f(w1_core_text, w1_core_key);

  aes_req_arbiter #(.WAIT_CYCLES(W), .BLOCK_W(BW)) u_dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_mode(a_mode), .a_text(a_text), .a_key(a_key),
    .b_valid(b_valid), .b_ready(b_ready), .b_mode(b_mode), .b_text(b_text), .b_key(b_key),
    .core_text(core_text), .core_key(core_key),
    .core_enc_result(core_enc_result), .core_dec_result(core_dec_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_mode(rsp_mode),
    .rsp_data(rsp_data), .busy(busy)
  );

  aes_req_arbiter #(.WAIT_CYCLES(1), .BLOCK_W(BW)) u_dut_w1 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(w1_a_ready), .a_mode(a_mode), .a_text(a_text), .a_key(a_key),
    .b_valid(b_valid), .b_ready(w1_b_ready), .b_mode(b_mode), .b_text(b_text), .b_key(b_key),
    .core_text(w1_core_text), .core_key(w1_core_key),
    .core_enc_result(w1_enc), .core_dec_result(w1_dec),
    .rsp_valid(w1_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(w1_rsp_id), .rsp_mode(w1_rsp_mode),
    .rsp_data(w1_rsp_data), .busy(w1_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 0; b_valid = 0; a_mode = 0; b_mode = 0; rsp_ready = 0;
    a_text = '0; a_key = '0; b_text = '0; b_key = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    n_vec++; if (rsp_id !== 1'b0 || rsp_mode !== 1'b0) begin n_err++; $display("FAIL reset_id_mode got %b%b exp 00", rsp_id, rsp_mode); end
    n_vec++; if (core_text !== '0 || core_key !== '0) begin n_err++; $display("FAIL reset_core got %h/%h exp 0", core_text, core_key); end
    n_vec++; if (rsp_data !== '0) begin n_err++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
    n_vec++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b%b exp 00", a_ready, b_ready); end
  endtask

  task automatic test_fips(input logic use_b, input logic mode, input logic [BW-1:0] text,
                           input logic [BW-1:0] key, input logic [BW-1:0] exp);
    int n;
    rsp_ready = 1'b1;
    if (use_b) begin b_valid = 1; b_mode = mode; b_text = text; b_key = key; end
    else       begin a_valid = 1; a_mode = mode; a_text = text; a_key = key; end
    #1;
    n_vec++; if ({b_ready, a_ready} !== (use_b ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL fips_grant got %b%b exp id %b", b_ready, a_ready, use_b); end
    tick();
    a_valid = 0; b_valid = 0;
    #1;
    n_vec++; if (busy !== 1'b1 || core_text !== text || core_key !== key) begin n_err++; $display("FAIL fips_core_latch got busy=%b %h/%h exp 1 %h/%h", busy, core_text, core_key, text, key); end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
    n_vec++; if (n != W) begin n_err++; $display("FAIL fips_latency got %0d exp %0d", n, W); end
    n_vec++; if (rsp_data !== exp) begin n_err++; $display("FAIL fips_data got %h exp %h", rsp_data, exp); end
    n_vec++; if (rsp_id !== use_b || rsp_mode !== mode) begin n_err++; $display("FAIL fips_tag got id=%b mode=%b exp %b %b", rsp_id, rsp_mode, use_b, mode); end
    tick();
    n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL fips_handshake got valid=%b busy=%b exp 0 0", rsp_valid, busy); end
    n_vec++; if (rsp_data !== exp || core_text !== text) begin n_err++; $display("FAIL fips_retain got %h/%h exp %h/%h", rsp_data, core_text, exp, text); end
  endtask

  task automatic test_alternate();
    logic [BW-1:0] exp_q[$];
    logic          id_q[$];
    int            n_acc, n_rsp;
    logic          took_a, took_b;
    do_reset();
    n_acc = 0; n_rsp = 0;
    rsp_ready = 1;
    a_valid = 1; a_mode = 1'($urandom); a_text = rnd128(); a_key = rnd128();
    b_valid = 1; b_mode = 1'($urandom); b_text = rnd128(); b_key = rnd128();
    for (int c = 0; c < 80 && n_rsp < 4; c++) begin
      #1;
      took_a = a_ready; took_b = b_ready;
      n_vec++; if (a_ready === 1'b1 && b_ready === 1'b1) begin n_err++; $display("FAIL alt_both_ready got 11 exp one-hot"); end
      if (took_a || took_b) begin
        n_vec++; if (took_b !== n_acc[0]) begin n_err++; $display("FAIL alt_grant_order got b=%b exp b=%b at accept %0d", took_b, n_acc[0], n_acc); end
        if (took_b) begin exp_q.push_back(expect_f(b_mode, b_text, b_key)); id_q.push_back(1'b1); end
        else        begin exp_q.push_back(expect_f(a_mode, a_text, a_key)); id_q.push_back(1'b0); end
        n_acc++;
      end
      if (rsp_valid === 1'b1 && exp_q.size() > 0) begin
        n_vec++; if (rsp_id !== n_rsp[0] || rsp_id !== id_q[0]) begin n_err++; $display("FAIL alt_rsp_id got %b exp %b", rsp_id, n_rsp[0]); end
        n_vec++; if (rsp_data !== exp_q[0]) begin n_err++; $display("FAIL alt_rsp_data got %h exp %h", rsp_data, exp_q[0]); end
        void'(exp_q.pop_front()); void'(id_q.pop_front());
        n_rsp++;
      end
      tick();
      if (took_a) begin a_mode = 1'($urandom); a_text = rnd128(); a_key = rnd128(); end
      if (took_b) begin b_mode = 1'($urandom); b_text = rnd128(); b_key = rnd128(); end
    end
    a_valid = 0; b_valid = 0;
    n_vec++; if (n_rsp != 4) begin n_err++; $display("FAIL alt_rsp_count got %0d exp 4", n_rsp); end
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] exp;
    int            n;
    bit            bad;
    rsp_ready = 0;
    a_valid = 1; a_mode = 0; a_text = rnd128(); a_key = rnd128();
    exp = expect_f(a_mode, a_text, a_key);
    #1;
    n_vec++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept got %b exp 1", a_ready); end
    tick();
    a_valid = 0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
    n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_rsp_timeout got %b exp 1", rsp_valid); end
    a_valid = 1; a_mode = 1; a_text = rnd128(); a_key = rnd128();
    b_valid = 1; b_mode = 0; b_text = rnd128(); b_key = rnd128();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (rsp_valid !== 1'b1 || rsp_data !== exp || rsp_id !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) bad = 1;
      tick();
    end
    n_vec++; if (bad) begin n_err++; $display("FAIL bp_hold got valid=%b data=%h ready=%b%b exp 1 %h 00", rsp_valid, rsp_data, a_ready, b_ready, exp); end
    rsp_ready = 1;
    tick();
    n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL bp_release got valid=%b busy=%b exp 0 0", rsp_valid, busy); end
    n_vec++; if ({b_ready, a_ready} !== 2'b10) begin n_err++; $display("FAIL bp_idle_grant got %b%b exp 10", b_ready, a_ready); end
    a_valid = 0; b_valid = 0;
    tick();
  endtask

  task automatic test_midop_reset();
    logic [BW-1:0] exp;
    int            n;
    bit            seen;
    do_reset();
    rsp_ready = 1;
    a_valid = 1; a_mode = 1; a_text = rnd128(); a_key = rnd128();
    tick();
    a_valid = 0;
    tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    #1;
    n_vec++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_flags got busy=%b valid=%b exp 0 0", busy, rsp_valid); end
    n_vec++; if (core_text !== '0 || core_key !== '0 || rsp_data !== '0) begin n_err++; $display("FAIL mid_rst_data got %h/%h/%h exp 0", core_text, core_key, rsp_data); end
    seen = 0;
    for (int i = 0; i < W + 4; i++) begin if (rsp_valid === 1'b1) seen = 1; tick(); end
    n_vec++; if (seen) begin n_err++; $display("FAIL mid_rst_no_rsp got 1 exp 0"); end
    a_valid = 1; a_mode = 0; a_text = rnd128(); a_key = rnd128();
    b_valid = 1; b_mode = 1; b_text = rnd128(); b_key = rnd128();
    exp = expect_f(a_mode, a_text, a_key);
    #1;
    n_vec++; if ({b_ready, a_ready} !== 2'b01) begin n_err++; $display("FAIL mid_rst_ptr got %b%b exp 01", b_ready, a_ready); end
    tick();
    a_valid = 0; b_valid = 0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
    n_vec++; if (n != W || rsp_data !== exp || rsp_id !== 1'b0) begin n_err++; $display("FAIL mid_rst_fresh got lat=%0d data=%h id=%b exp %0d %h 0", n, rsp_data, rsp_id, W, exp); end
    tick();
  endtask

  // Transaction-level reference: an op occupies the engine from its accept edge,
  // its result appears W edges later, and the engine frees on the handshake edge.
  task automatic test_random();
    bit            m_busy, m_rsp, m_fav_b, m_id, m_mode;
    int            m_cnt;
    logic [BW-1:0] m_text, m_exp;
    bit            exp_a, exp_b, hs;
    do_reset();
    m_busy = 0; m_rsp = 0; m_fav_b = 0; m_cnt = 0; m_id = 0; m_mode = 0; m_text = '0; m_exp = '0;
    rsp_ready = 1;
    for (int c = 0; c < 400; c++) begin
      #1;
      exp_a = !m_busy && a_valid && (!b_valid || !m_fav_b);
      exp_b = !m_busy && b_valid && (!a_valid || m_fav_b);
      n_vec++; if (a_ready !== exp_a || b_ready !== exp_b) begin n_err++; $display("FAIL rnd_ready c=%0d got %b%b exp %b%b", c, b_ready, a_ready, exp_b, exp_a); end
      n_vec++; if (rsp_valid !== m_rsp || busy !== m_busy) begin n_err++; $display("FAIL rnd_flags c=%0d got v=%b busy=%b exp %b %b", c, rsp_valid, busy, m_rsp, m_busy); end
      if (m_rsp) begin
        n_vec++; if (rsp_data !== m_exp || rsp_id !== m_id || rsp_mode !== m_mode) begin n_err++; $display("FAIL rnd_rsp c=%0d got %h id=%b m=%b exp %h %b %b", c, rsp_data, rsp_id, rsp_mode, m_exp, m_id, m_mode); end
      end
      if (m_busy) begin
        n_vec++; if (core_text !== m_text) begin n_err++; $display("FAIL rnd_core c=%0d got %h exp %h", c, core_text, m_text); end
      end
      hs = m_rsp && rsp_ready;
      tick();
      if (exp_a || exp_b) begin
        m_busy = 1; m_cnt = W; m_id = exp_b;
        m_mode = exp_b ? b_mode : a_mode;
        m_text = exp_b ? b_text : a_text;
        m_exp  = exp_b ? expect_f(b_mode, b_text, b_key) : expect_f(a_mode, a_text, a_key);
        m_fav_b = exp_a;
      end else if (m_busy && !m_rsp) begin
        m_cnt--;
        if (m_cnt == 0) m_rsp = 1;
      end else if (hs) begin
        m_rsp = 0; m_busy = 0;
      end
      if (exp_a || !a_valid) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_mode = 1'($urandom); a_text = rnd128(); a_key = rnd128();
      end
      if (exp_b || !b_valid) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_mode = 1'($urandom); b_text = rnd128(); b_key = rnd128();
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
    end
    a_valid = 0; b_valid = 0;
  endtask

  task automatic test_w1();
    int            acc_c[$];
    int            rsp_c[$];
    logic [BW-1:0] exp_first;
    logic [BW-1:0] got_first;
    bit            spacing_bad;
    do_reset();
    rsp_ready = 1;
    got_first = '0;
    a_valid = 1; a_mode = 0; a_text = rnd128(); a_key = rnd128();
    exp_first = expect_f(a_mode, a_text, a_key);
    for (int c = 0; c < 20; c++) begin
      #1;
      if (w1_rsp_valid === 1'b1) begin
        if (rsp_c.size() == 0) got_first = w1_rsp_data;
        rsp_c.push_back(c);
      end
      if (w1_a_ready === 1'b1) begin
        acc_c.push_back(c);
        tick();
        a_mode = 1'($urandom); a_text = rnd128(); a_key = rnd128();
      end else begin
        tick();
      end
    end
    a_valid = 0;
    n_vec++; if (acc_c.size() < 3 || rsp_c.size() < 1) begin n_err++; $display("FAIL w1_activity got acc=%0d rsp=%0d exp >=3 >=1", acc_c.size(), rsp_c.size()); end
    else begin
      n_vec++; if (rsp_c[0] != acc_c[0] + 2) begin n_err++; $display("FAIL w1_latency got rsp cycle %0d exp %0d", rsp_c[0], acc_c[0] + 2); end
      n_vec++; if (got_first !== exp_first) begin n_err++; $display("FAIL w1_data got %h exp %h", got_first, exp_first); end
      spacing_bad = 0;
      for (int i = 1; i < acc_c.size(); i++) if (acc_c[i] - acc_c[i-1] != 3) spacing_bad = 1;
      n_vec++; if (spacing_bad) begin n_err++; $display("FAIL w1_issue_interval got %0d exp 3", acc_c[1] - acc_c[0]); end
    end
    tick(); tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fips(1'b0, 1'b0, FIPS_PT, FIPS_KEY, FIPS_CT);
    test_fips(1'b1, 1'b1, FIPS_CT, FIPS_KEY, FIPS_PT);
    test_alternate();
    test_backpressure();
    test_midop_reset();
    test_random();
    test_w1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
